// File: rtl/apb_iic_master_regs_fifo.sv
// APB register file for the IIC master: config registers, byte-wide TX/RX FIFOs, sticky W1C interrupts.
// Define IICM_FIFO_THRESH_EN to add FIFO level thresholds (reg 0x30, INT_RAW bits 8/9).

module apb_iic_master_regs_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        pclk,
    input  logic        prstn,
    input  logic        i_psel,
    input  logic        i_penable,
    input  logic        i_pwrite,
    input  logic [23:0] i_paddr,
    input  logic [31:0] i_pwdata,
    output logic [31:0] o_prdata,
    output logic        o_pready,
    input  logic        i_core_busy,
    input  logic        i_ev_done,
    input  logic        i_ev_timeout,
    input  logic        i_ev_nstop,
    input  logic        i_ev_nack,
    input  logic        i_tx_pop,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_empty,
    input  logic        i_rx_push,
    input  logic [7:0]  i_rx_data,
    output logic [7:0]  o_slave_addr,
    output logic [7:0]  o_nword,
    output logic [3:0]  o_cmd,
    output logic        o_cmd_valid,
    output logic [15:0] o_time_out,
    output logic [15:0] o_clk_div,
    output logic        o_clk_en,
    output logic        o_clk_str_en,
    output logic        o_last_ack_en,
    output logic        o_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef IICM_FIFO_THRESH_EN
    localparam int INT_W = 10;
`else
    localparam int INT_W = 8;
`endif

    logic [7:0]       r_slave_addr, r_nword;
    logic [3:0]       r_cmd;
    logic             r_cmd_valid;
    logic [15:0]      r_time_out, r_clk_div;
    logic             r_clk_en, r_clk_str_en, r_last_ack_en;
    logic             r_tx_flush, r_rx_flush;
    logic [INT_W-1:0] r_int_raw, r_int_en;
    logic             r_irq;
    logic [31:0]      r_prdata;

    logic [7:0]       r_tx_mem [FIFO_DEPTH];
    logic [7:0]       r_rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;

    logic             w_setup, w_wr, w_rd;
    logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic             w_tx_push_req, w_tx_push_ok, w_tx_pop_ok, w_tx_ovf;
    logic             w_rx_pop_req, w_rx_pop_ok, w_rx_push_ok, w_rx_ovf, w_rx_udf;
    logic             w_cmd_err;
    logic [5:0]       w_tx_cnt6, w_rx_cnt6;
    logic [INT_W-1:0] w_int_set, w_int_clr;
    logic [31:0]      w_rdata;

    assign w_setup = i_psel & ~i_penable;
    assign w_wr    = w_setup & i_pwrite;
    assign w_rd    = w_setup & ~i_pwrite;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CNT_W'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_W'(FIFO_DEPTH));
    assign w_tx_cnt6  = 6'(r_tx_cnt);
    assign w_rx_cnt6  = 6'(r_rx_cnt);

    // A pending flush wins over any push/pop in the same cycle.
    assign w_tx_pop_ok   = i_tx_pop & ~w_tx_empty & ~r_tx_flush;
    assign w_tx_push_req = w_wr & (i_paddr == 24'h18) & ~r_tx_flush;
    assign w_tx_push_ok  = w_tx_push_req & (~w_tx_full | w_tx_pop_ok);
    assign w_tx_ovf      = w_tx_push_req & ~w_tx_push_ok;

    assign w_rx_pop_req = w_rd & (i_paddr == 24'h1C);
    assign w_rx_pop_ok  = w_rx_pop_req & ~w_rx_empty & ~r_rx_flush;
    assign w_rx_udf     = w_rx_pop_req & w_rx_empty;
    assign w_rx_push_ok = i_rx_push & ~r_rx_flush & (~w_rx_full | w_rx_pop_ok);
    assign w_rx_ovf     = i_rx_push & ~r_rx_flush & ~w_rx_push_ok;

    assign w_cmd_err = w_wr & (i_paddr == 24'h08) & i_core_busy;
    assign w_int_clr = (w_wr && i_paddr == 24'h24) ? i_pwdata[INT_W-1:0] : '0;

`ifdef IICM_FIFO_THRESH_EN
    logic [5:0] r_tx_th, r_rx_th;
    logic       r_tx_lvl_d, r_rx_lvl_d;
    logic       w_tx_lvl, w_rx_lvl;

    assign w_tx_lvl = (int'(r_tx_cnt) <= int'(r_tx_th));
    assign w_rx_lvl = (r_rx_th != '0) && (int'(r_rx_cnt) >= int'(r_rx_th));

    // Level history resets to the post-reset level so reset itself raises no edge.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_tx_th    <= '0;
            r_rx_th    <= '0;
            r_tx_lvl_d <= 1'b1;
            r_rx_lvl_d <= 1'b0;
        end else begin
            r_tx_lvl_d <= w_tx_lvl;
            r_rx_lvl_d <= w_rx_lvl;
            if (w_wr && i_paddr == 24'h30) begin
                r_tx_th <= i_pwdata[5:0];
                r_rx_th <= i_pwdata[13:8];
            end
        end
    end
`endif

    always_comb begin
        w_int_set    = '0;
        w_int_set[0] = i_ev_nack;
        w_int_set[1] = i_ev_nstop;
        w_int_set[2] = i_ev_timeout;
        w_int_set[3] = i_ev_done;
        w_int_set[4] = w_tx_ovf;
        w_int_set[5] = w_rx_ovf;
        w_int_set[6] = w_rx_udf;
        w_int_set[7] = w_cmd_err;
`ifdef IICM_FIFO_THRESH_EN
        w_int_set[8] = w_tx_lvl & ~r_tx_lvl_d;
        w_int_set[9] = w_rx_lvl & ~r_rx_lvl_d;
`endif
    end

    always_comb begin
        w_rdata = '0;
        case (i_paddr)
            24'h00: w_rdata = {24'h0, r_slave_addr};
            24'h04: w_rdata = {24'h0, r_nword};
            24'h0C: w_rdata = {16'h0, r_time_out};
            24'h10: w_rdata = {28'h0, r_rx_flush, r_tx_flush, r_last_ack_en, r_clk_str_en};
            24'h14: w_rdata = {16'h0, r_clk_div};
            24'h1C: if (!w_rx_empty) w_rdata = {24'h0, r_rx_mem[r_rx_rp]};
            24'h20: w_rdata = {10'h0, w_rx_cnt6, 2'b0, w_tx_cnt6, 4'h0,
                               w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
            24'h24: w_rdata = 32'(r_int_raw);
            24'h28: w_rdata = 32'(r_int_en);
            24'h2C: w_rdata = 32'(r_int_raw & r_int_en);
`ifdef IICM_FIFO_THRESH_EN
            24'h30: w_rdata = {18'h0, r_rx_th, 2'b0, r_tx_th};
`endif
            24'h38: w_rdata = {31'h0, r_clk_en};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_slave_addr  <= 8'h0F;
            r_nword       <= 8'h0F;
            r_cmd         <= '0;
            r_cmd_valid   <= 1'b0;
            r_time_out    <= '0;
            r_clk_div     <= 16'h0010;
            r_clk_en      <= 1'b0;
            r_clk_str_en  <= 1'b0;
            r_last_ack_en <= 1'b0;
            r_tx_flush    <= 1'b0;
            r_rx_flush    <= 1'b0;
            r_int_raw     <= '0;
            r_int_en      <= '0;
            r_irq         <= 1'b0;
            r_prdata      <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_tx_flush  <= 1'b0;
            r_rx_flush  <= 1'b0;
            r_int_raw   <= (r_int_raw & ~w_int_clr) | w_int_set;
            r_irq       <= |(r_int_raw & r_int_en);
            if (w_rd) r_prdata <= w_rdata;
            if (w_wr) begin
                case (i_paddr)
                    24'h00: r_slave_addr <= i_pwdata[7:0];
                    24'h04: r_nword      <= i_pwdata[7:0];
                    24'h08: if (!i_core_busy) begin
                        r_cmd       <= i_pwdata[3:0];
                        r_cmd_valid <= 1'b1;
                    end
                    24'h0C: r_time_out <= i_pwdata[15:0];
                    24'h10: begin
                        r_clk_str_en  <= i_pwdata[0];
                        r_last_ack_en <= i_pwdata[1];
                        r_tx_flush    <= i_pwdata[2];
                        r_rx_flush    <= i_pwdata[3];
                    end
                    24'h14: r_clk_div <= i_pwdata[15:0];
                    24'h28: r_int_en  <= i_pwdata[INT_W-1:0];
                    24'h38: r_clk_en  <= i_pwdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (r_tx_flush) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_tx_push_ok) r_tx_wp <= r_tx_wp + PTR_W'(1);
                if (w_tx_pop_ok)  r_tx_rp <= r_tx_rp + PTR_W'(1);
                r_tx_cnt <= r_tx_cnt + CNT_W'(w_tx_push_ok) - CNT_W'(w_tx_pop_ok);
            end
            if (r_rx_flush) begin
                r_rx_wp  <= '0;
                r_rx_rp  <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_rx_push_ok) r_rx_wp <= r_rx_wp + PTR_W'(1);
                if (w_rx_pop_ok)  r_rx_rp <= r_rx_rp + PTR_W'(1);
                r_rx_cnt <= r_rx_cnt + CNT_W'(w_rx_push_ok) - CNT_W'(w_rx_pop_ok);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (w_tx_push_ok) r_tx_mem[r_tx_wp] <= i_pwdata[7:0];
        if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= i_rx_data;
    end

    assign o_prdata      = r_prdata;
    assign o_pready      = 1'b1;
    assign o_tx_data     = r_tx_mem[r_tx_rp];
    assign o_tx_empty    = w_tx_empty;
    assign o_slave_addr  = r_slave_addr;
    assign o_nword       = r_nword;
    assign o_cmd         = r_cmd;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_time_out    = r_time_out;
    assign o_clk_div     = r_clk_div;
    assign o_clk_en      = r_clk_en;
    assign o_clk_str_en  = r_clk_str_en;
    assign o_last_ack_en = r_last_ack_en;
    assign o_irq         = r_irq;

endmodule
